mult_block_buffer: RTL and testbench

- Parametrised successor to the team's multiply-then-block-read buffer.
- Accepts operand pairs over a valid/ready handshake and multiplies them, signed or unsigned. Each product, or each running sum of products, is written to an external single-port memory.
- Once a run-time-programmable number of entries is filled, it streams them back on request. The stream can be paused, and an abort can cancel it.
- Sits between the operand source and the result memory/consumer.

---
 rtl/mult_buf_pkg.sv | 21 ++
 rtl/mult_buf_mult_unit.sv | 43 ++++
 rtl/mult_block_buffer.sv | 176 +++++++++++++++++
 tb/tb_mult_block_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_buf_pkg
// Description : Shared types for the multiply-then-block-read buffer.
//               Holds the controller state encoding.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package mult_buf_pkg;

  localparam int c_STATE_W = 3;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FULL  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_buf_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit
// Description : Combinational IN_WIDTH x IN_WIDTH multiplier, signed or
//               unsigned, with the 2*IN_WIDTH product extended to WIDTH.
// Ports       : a, b      - operands
//               is_signed - 1 = two's-complement operands
//               product   - extended product (WIDTH bits)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mult_unit #(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  input  logic                is_signed,
  output logic [WIDTH-1:0]    product
);

  localparam int c_PW = 2 * IN_WIDTH;

  logic [c_PW-1:0] w_ax;
  logic [c_PW-1:0] w_bx;
  logic [c_PW-1:0] w_prod;

  // Extending both operands to the full product width first lets a single
  // unsigned multiplier serve both modes: modulo 2**c_PW the product of the
  // sign-extended operands equals the true signed product.
  assign w_ax   = is_signed ? {{IN_WIDTH{a[IN_WIDTH-1]}}, a} : {{IN_WIDTH{1'b0}}, a};
  assign w_bx   = is_signed ? {{IN_WIDTH{b[IN_WIDTH-1]}}, b} : {{IN_WIDTH{1'b0}}, b};
  assign w_prod = w_ax * w_bx;

  generate
    if (WIDTH > c_PW) begin : g_ext
      assign product = {{(WIDTH-c_PW){is_signed & w_prod[c_PW-1]}}, w_prod};
    end else begin : g_exact
      assign product = w_prod[WIDTH-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mult_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mult_block_buffer
// Description : Accepts operand pairs, writes each product (or running sum)
//               to an external single-port memory, and once cfg_len+1
//               entries are written streams them back on request.
// Ports       : clk, rst (async, active low)
//               cfg_len/cfg_signed/cfg_accum - block config, latched on the
//                                              first accepted operand
//               abort                        - synchronous cancel
//               EN_mult/RDY_mult/mult_input* - operand handshake
//               EN_writeMem/writeMem_*       - memory write port
//               RDY_blockRead/EN_blockRead   - read-out handshake
//               EN_readMem/readMem_*         - memory read port
//               VALID_memVal/memVal_data     - streamed words
//               blk_done                     - pulse with the last word
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mult_block_buffer
  import mult_buf_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32,
  parameter int LOGDEPTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOGDEPTH-1:0] cfg_len,
  input  logic                cfg_signed,
  input  logic                cfg_accum,
  input  logic                abort,
  input  logic                EN_mult,
  output logic                RDY_mult,
  input  logic [IN_WIDTH-1:0] mult_input0,
  input  logic [IN_WIDTH-1:0] mult_input1,
  output logic                EN_writeMem,
  output logic [LOGDEPTH-1:0] writeMem_addr,
  output logic [WIDTH-1:0]    writeMem_val,
  output logic                RDY_blockRead,
  input  logic                EN_blockRead,
  output logic                EN_readMem,
  output logic [LOGDEPTH-1:0] readMem_addr,
  input  logic [WIDTH-1:0]    readMem_val,
  output logic                VALID_memVal,
  output logic [WIDTH-1:0]    memVal_data,
  output logic                blk_done
);

  state_t r_state, w_next_state;

  logic [LOGDEPTH-1:0] r_len, r_wr_cnt, r_rd_cnt;
  logic                r_signed, r_accum;
  logic [WIDTH-1:0]    r_acc;
  logic                r_rdy_mult, r_rdy_blockread;
  logic                r_en_wr, r_en_rd, r_valid, r_blk_done;
  logic [LOGDEPTH-1:0] r_wr_addr, r_rd_addr;
  logic [WIDTH-1:0]    r_wr_val;

  logic                w_in_idle, w_accept, w_issue, w_last_wr, w_last_rd;
  logic                w_signed, w_accum;
  logic [LOGDEPTH-1:0] w_wr_addr, w_rd_addr;
  logic [WIDTH-1:0]    w_prod, w_base, w_sum;

  // In IDLE the configuration has not been latched yet, so the first operand
  // uses the live cfg_* inputs and starts from a clean count/accumulator.
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = EN_mult && r_rdy_mult;
  assign w_signed  = w_in_idle ? cfg_signed : r_signed;
  assign w_accum   = w_in_idle ? cfg_accum  : r_accum;
  assign w_wr_addr = w_in_idle ? '0 : r_wr_cnt;
  assign w_last_wr = w_in_idle ? (cfg_len == '0) : (r_wr_cnt == r_len);
  assign w_base    = w_in_idle ? '0 : r_acc;
  assign w_sum     = w_base + w_prod;

  // The request seen in FULL issues address 0 straight away, so the first
  // memory read lands on the cycle after the last write.
  assign w_issue   = EN_blockRead && ((r_state == ST_FULL) || (r_state == ST_READ));
  assign w_rd_addr = (r_state == ST_FULL) ? '0 : r_rd_cnt;
  assign w_last_rd = (w_rd_addr == r_len);

  mult_unit #(
    .IN_WIDTH (IN_WIDTH),
    .WIDTH    (WIDTH)
  ) u_mult (
    .a         (mult_input0),
    .b         (mult_input1),
    .is_signed (w_signed),
    .product   (w_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_next_state = w_last_wr ? ST_FULL : ST_FILL;
        ST_FILL:  if (w_accept && w_last_wr) w_next_state = ST_FULL;
        ST_FULL:  if (EN_blockRead) w_next_state = w_last_rd ? ST_DRAIN : ST_READ;
        ST_READ:  if (EN_blockRead && w_last_rd) w_next_state = ST_DRAIN;
        ST_DRAIN: w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len           <= '0;
      r_signed        <= 1'b0;
      r_accum         <= 1'b0;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_acc           <= '0;
      r_rdy_mult      <= 1'b0;
      r_rdy_blockread <= 1'b0;
      r_en_wr         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_val        <= '0;
      r_en_rd         <= 1'b0;
      r_rd_addr       <= '0;
      r_valid         <= 1'b0;
      r_blk_done      <= 1'b0;
    end else begin
      // Ready flags follow the state being entered so they are valid the
      // same cycle that state becomes current.
      r_rdy_mult      <= (w_next_state == ST_IDLE) || (w_next_state == ST_FILL);
      r_rdy_blockread <= (w_next_state == ST_FULL);
      r_en_wr         <= w_accept && !abort;
      r_en_rd         <= w_issue && !abort;
      // An in-flight read is dropped by abort rather than reported.
      r_valid         <= r_en_rd && !abort;
      r_blk_done      <= (r_state == ST_DRAIN) && !abort;

      if (abort) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
        r_acc    <= '0;
      end else begin
        if (w_accept) begin
          if (w_in_idle) begin
            r_len    <= cfg_len;
            r_signed <= cfg_signed;
            r_accum  <= cfg_accum;
          end
          r_wr_cnt  <= w_wr_addr + LOGDEPTH'(1);
          r_acc     <= w_sum;
          r_wr_addr <= w_wr_addr;
          r_wr_val  <= w_accum ? w_sum : w_prod;
        end
        if (w_issue) begin
          r_rd_cnt  <= w_rd_addr + LOGDEPTH'(1);
          r_rd_addr <= w_rd_addr;
        end
      end
    end
  end

  assign RDY_mult      = r_rdy_mult;
  assign RDY_blockRead = r_rdy_blockread;
  assign EN_writeMem   = r_en_wr;
  assign writeMem_addr = r_wr_addr;
  assign writeMem_val  = r_wr_val;
  assign EN_readMem    = r_en_rd;
  assign readMem_addr  = r_rd_addr;
  assign VALID_memVal  = r_valid;
  assign memVal_data   = readMem_val;
  assign blk_done      = r_blk_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_block_buffer
// Description : Self-checking bench for mult_block_buffer. A behavioural
//               model predicts every memory write and every streamed word;
//               a compare process checks them on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_block_buffer;

  localparam int c_IW = 16;
  localparam int c_W  = 32;
  localparam int c_LD = 6;
  localparam int c_DEPTH = 1 << c_LD;

  logic            clk = 1'b0;
  logic            rst;
  logic [c_LD-1:0] cfg_len;
  logic            cfg_signed, cfg_accum, abort;
  logic            EN_mult, RDY_mult;
  logic [c_IW-1:0] mult_input0, mult_input1;
  logic            EN_writeMem;
  logic [c_LD-1:0] writeMem_addr;
  logic [c_W-1:0]  writeMem_val;
  logic            RDY_blockRead, EN_blockRead, EN_readMem;
  logic [c_LD-1:0] readMem_addr;
  logic [c_W-1:0]  readMem_val = '0;
  logic            VALID_memVal;
  logic [c_W-1:0]  memVal_data;
  logic            blk_done;

  mult_block_buffer #(.IN_WIDTH(c_IW), .WIDTH(c_W), .LOGDEPTH(c_LD)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .cfg_accum(cfg_accum), .abort(abort), .EN_mult(EN_mult), .RDY_mult(RDY_mult),
    .mult_input0(mult_input0), .mult_input1(mult_input1),
    .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .RDY_blockRead(RDY_blockRead), .EN_blockRead(EN_blockRead),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr), .readMem_val(readMem_val),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  // External single-port memory with one-cycle read latency.
  logic [c_W-1:0] mem [c_DEPTH];
  always @(posedge clk) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem)  readMem_val <= mem[readMem_addr];
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; bit last; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  logic [31:0] exp_mem [c_DEPTH];
  logic [31:0] wr_log  [c_DEPTH];
  int          m_len, m_idx;
  bit          m_sg, m_ac, rd_allowed;
  logic [31:0] m_acc;

  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b, input bit sg);
    longint x, y;
    if (sg) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else    begin x = longint'(a);          y = longint'(b);          end
    return 32'(x * y);
  endfunction

  task automatic start_block(input int len, input bit sg, input bit ac);
    cfg_len = c_LD'(len); cfg_signed = sg; cfg_accum = ac;
    m_len = len; m_sg = sg; m_ac = ac; m_idx = 0; m_acc = '0;
  endtask

  task automatic model_push(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p, v;
    p = model_prod(a, b, m_sg);
    if (m_ac) begin m_acc = m_acc + p; v = m_acc; end
    else v = p;
    wq.push_back('{m_idx, v});
    exp_mem[m_idx] = v;
    m_idx++;
    if (m_idx == m_len + 1) begin
      for (int i = 0; i <= m_len; i++) rq.push_back('{exp_mem[i], (i == m_len)});
      rd_allowed = 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (EN_writeMem) begin
      wr_log[writeMem_addr] = writeMem_val;
      if (wq.size() == 0) check("wr_unexpected", 64'(EN_writeMem), 64'(0));
      else begin
        wr_t e;
        e = wq.pop_front();
        check("wr_addr", 64'(writeMem_addr), 64'(e.addr));
        check("wr_data", 64'(writeMem_val), 64'(e.data));
      end
    end
    if (!rd_allowed) check("rd_gate", 64'(EN_readMem), 64'(0));
    if (VALID_memVal) begin
      if (rq.size() == 0) check("valid_unexpected", 64'(VALID_memVal), 64'(0));
      else begin
        rd_t r;
        r = rq.pop_front();
        check("rd_data", 64'(memVal_data), 64'(r.data));
        check("blk_done_align", 64'(blk_done), 64'(r.last));
      end
    end else if (blk_done) begin
      check("blk_done_unexpected", 64'(blk_done), 64'(0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int k;
    EN_mult = 1'b1; mult_input0 = a; mult_input1 = b;
    k = 0;
    while (!RDY_mult && k < 100) begin tick(); k++; end
    if (!RDY_mult) begin
      check("accept_timeout", 64'(RDY_mult), 64'(1));
      EN_mult = 1'b0;
      return;
    end
    model_push(a, b);
    tick();
    EN_mult = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      if (blk_done) seen = 1'b1;
    end
    check("blk_done_seen", 64'(seen), 64'(1));
  endtask

  task automatic read_block(input int hi, input int lo);
    EN_blockRead = 1'b1;
    if (lo > 0) begin
      repeat (hi) tick();
      EN_blockRead = 1'b0;
      repeat (lo) tick();
      EN_blockRead = 1'b1;
    end
    wait_done(200);
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
    rd_allowed = 1'b0;
    check("rdy_mult_after_done", 64'(RDY_mult), 64'(1));
    check("rdy_blk_after_done", 64'(RDY_blockRead), 64'(0));
    tick();
    check("rd_all_streamed", 64'(rq.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy_mult"}, 64'(RDY_mult), 64'(0));
    check({tag, "_en_wr"}, 64'({EN_writeMem, writeMem_addr, writeMem_val}), 64'(0));
    check({tag, "_rdy_blk"}, 64'(RDY_blockRead), 64'(0));
    check({tag, "_en_rd"}, 64'({EN_readMem, readMem_addr}), 64'(0));
    check({tag, "_valid_done"}, 64'({VALID_memVal, blk_done}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    rst = 1'b1; abort = 1'b0; EN_mult = 1'b0; EN_blockRead = 1'b0;
    mult_input0 = '0; mult_input1 = '0; rd_allowed = 1'b0;
    start_block(0, 0, 0);
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    tick(); tick();
    rst = 1'b1;
    check("rdy_before_first_clk", 64'(RDY_mult), 64'(0));
    tick();
    check("rdy_after_release", 64'(RDY_mult), 64'(1));

    // Unsigned, back-to-back operands.
    start_block(3, 0, 0);
    send(16'd2, 16'd3);
    send(16'd4, 16'd5);
    send(16'hFFFF, 16'hFFFF);
    send(16'd1, 16'd1);
    check("u_rdy_mult_low", 64'(RDY_mult), 64'(0));
    check("u_rdy_blk_high", 64'(RDY_blockRead), 64'(1));
    @(negedge clk); #1;
    check("u_lit0", 64'(wr_log[0]), 64'h6);
    check("u_lit1", 64'(wr_log[1]), 64'd20);
    check("u_lit2", 64'(wr_log[2]), 64'hFFFE0001);
    check("u_lit3", 64'(wr_log[3]), 64'h1);
    // Operands offered during FULL/READ must be ignored.
    EN_mult = 1'b1; mult_input0 = 16'd9; mult_input1 = 16'd9;
    read_block(0, 0);

    // Signed accumulate with a gap; read requested during FILL.
    start_block(2, 1, 1);
    EN_blockRead = 1'b1;
    send(16'hFFFD, 16'd4);
    cfg_len = 6'd5; cfg_signed = 1'b0; cfg_accum = 1'b0;
    tick();
    send(16'd5, 16'd5);
    send(16'hFFFF, 16'd1);
    @(negedge clk); #1;
    check("s_lit0", 64'(wr_log[0]), 64'hFFFFFFF4);
    check("s_lit1", 64'(wr_log[1]), 64'h0000000D);
    check("s_lit2", 64'(wr_log[2]), 64'h0000000C);
    read_block(0, 0);

    // Full depth with a paused read.
    start_block(63, 0, 0);
    for (int i = 0; i < c_DEPTH; i++) send(16'(i), 16'd1);
    check("f_rdy_blk_high", 64'(RDY_blockRead), 64'(1));
    read_block(10, 3);

    // Abort in READ once addresses 0..4 are issued.
    start_block(7, 0, 0);
    for (int i = 0; i < 8; i++) send(16'(i + 100), 16'd1);
    EN_blockRead = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
        tick();
        if (EN_readMem && readMem_addr == 6'd4) hit = 1'b1;
      end
      check("abort_reached_addr4", 64'(hit), 64'(1));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; EN_blockRead = 1'b0;
    rq.delete(); rd_allowed = 1'b0;
    check("abort_rdy_mult", 64'(RDY_mult), 64'(1));
    check("abort_strobes", 64'({EN_readMem, VALID_memVal, blk_done, EN_writeMem}), 64'(0));
    repeat (4) tick();

    // Single-entry block after abort.
    start_block(0, 0, 0);
    send(16'd7, 16'd9);
    check("one_rdy_blk", 64'(RDY_blockRead), 64'(1));
    @(negedge clk); #1;
    check("one_lit0", 64'(wr_log[0]), 64'd63);
    read_block(0, 0);

    // Reset mid-FILL while a write strobe is showing.
    start_block(5, 0, 0);
    send(16'd1, 16'd2);
    @(negedge clk); #1;
    send(16'd3, 16'd4);
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    wq.delete(); rq.delete(); rd_allowed = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("midrst_rdy_low", 64'(RDY_mult), 64'(0));
    tick();
    check("midrst_rdy_high", 64'(RDY_mult), 64'(1));
    tick();

    check("wq_drained", 64'(wq.size()), 64'(0));
    check("rq_drained", 64'(rq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
